bus_fabric: RTL and testbench

- Shared-bus interconnect for the SoC.
- Arbitrates four bus masters (CPU instruction/data ports plus two spare masters) with round-robin ownership.
- Forwards the owner's address, strobe, read/write and write data to a shared slave bus, decodes eight slave chip-selects from the top address bits, and returns the selected slave's read data and ready to all masters.
- Combinational datapath; the only state is the owner register.

---
 rtl/bus_fabric_if.sv | 58 +++++
 rtl/bus_fabric.sv | 106 ++++++++++
 tb/tb_bus_fabric.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// Shared-bus signal bundle: four masters, the forwarded slave bus, eight
// slave chip-selects/read paths and the broadcast read-return path.
interface bus_fabric_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  // master side
  logic              m0Req_, m1Req_, m2Req_, m3Req_;
  logic              m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
  logic [ADDR_W-1:0] m0Addr, m1Addr, m2Addr, m3Addr;
  logic              m0As_, m1As_, m2As_, m3As_;
  logic              m0RW, m1RW, m2RW, m3RW;
  logic [DATA_W-1:0] m0Data, m1Data, m2Data, m3Data;
  // shared slave bus
  logic [ADDR_W-1:0] sAddr;
  logic              sAs_;
  logic              sRW;
  logic [DATA_W-1:0] sData;
  logic              s0CS_, s1CS_, s2CS_, s3CS_, s4CS_, s5CS_, s6CS_, s7CS_;
  logic [DATA_W-1:0] s0RdData, s1RdData, s2RdData, s3RdData;
  logic [DATA_W-1:0] s4RdData, s5RdData, s6RdData, s7RdData;
  logic              s0Rdy_, s1Rdy_, s2Rdy_, s3Rdy_, s4Rdy_, s5Rdy_, s6Rdy_, s7Rdy_;
  // read return broadcast
  logic [DATA_W-1:0] mRdData;
  logic              mRdy_;

  // The fabric's view: it owns the shared slave bus and returns grants/read data.
  modport master (
    input  m0Req_, m1Req_, m2Req_, m3Req_,
    input  m0Addr, m1Addr, m2Addr, m3Addr,
    input  m0As_, m1As_, m2As_, m3As_,
    input  m0RW, m1RW, m2RW, m3RW,
    input  m0Data, m1Data, m2Data, m3Data,
    input  s0RdData, s1RdData, s2RdData, s3RdData,
    input  s4RdData, s5RdData, s6RdData, s7RdData,
    input  s0Rdy_, s1Rdy_, s2Rdy_, s3Rdy_, s4Rdy_, s5Rdy_, s6Rdy_, s7Rdy_,
    output m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
    output sAddr, sAs_, sRW, sData,
    output s0CS_, s1CS_, s2CS_, s3CS_, s4CS_, s5CS_, s6CS_, s7CS_,
    output mRdData, mRdy_
  );

  // The environment's view: bus masters and slaves attached to the fabric.
  modport slave (
    output m0Req_, m1Req_, m2Req_, m3Req_,
    output m0Addr, m1Addr, m2Addr, m3Addr,
    output m0As_, m1As_, m2As_, m3As_,
    output m0RW, m1RW, m2RW, m3RW,
    output m0Data, m1Data, m2Data, m3Data,
    output s0RdData, s1RdData, s2RdData, s3RdData,
    output s4RdData, s5RdData, s6RdData, s7RdData,
    output s0Rdy_, s1Rdy_, s2Rdy_, s3Rdy_, s4Rdy_, s5Rdy_, s6Rdy_, s7Rdy_,
    input  m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
    input  sAddr, sAs_, sRW, sData,
    input  s0CS_, s1CS_, s2CS_, s3CS_, s4CS_, s5CS_, s6CS_, s7CS_,
    input  mRdData, mRdy_
  );
endinterface

// File: rtl/bus_fabric.sv
// Four-master round-robin shared-bus interconnect with eight-way slave decode.
// The 2-bit owner register is the only state; everything else is combinational.
module bus_fabric #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic         clk,
  input  logic         reset_,
  bus_fabric_if.master bus
);

  logic [1:0]        owner_q, owner_d;
  logic [1:0]        scan_idx;
  logic              scan_found;
  logic [3:0]        req;
  logic [3:0]        grant_n;
  logic [ADDR_W-1:0] m_addr [4];
  logic              m_as_n [4];
  logic              m_rw   [4];
  logic [DATA_W-1:0] m_data [4];
  logic [DATA_W-1:0] s_rd   [8];
  logic [7:0]        s_rdy_n;
  logic [SEL_W-1:0]  sel;
  logic [7:0]        cs_n;

  // Gather the named interface signals into indexable arrays (requests active high).
  assign req     = ~{bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_};
  assign m_addr  = '{bus.m0Addr, bus.m1Addr, bus.m2Addr, bus.m3Addr};
  assign m_as_n  = '{bus.m0As_, bus.m1As_, bus.m2As_, bus.m3As_};
  assign m_rw    = '{bus.m0RW, bus.m1RW, bus.m2RW, bus.m3RW};
  assign m_data  = '{bus.m0Data, bus.m1Data, bus.m2Data, bus.m3Data};
  assign s_rd    = '{bus.s0RdData, bus.s1RdData, bus.s2RdData, bus.s3RdData,
                     bus.s4RdData, bus.s5RdData, bus.s6RdData, bus.s7RdData};
  assign s_rdy_n = {bus.s7Rdy_, bus.s6Rdy_, bus.s5Rdy_, bus.s4Rdy_,
                    bus.s3Rdy_, bus.s2Rdy_, bus.s1Rdy_, bus.s0Rdy_};

  // Owner register; reset parks ownership on master 0.
  always_ff @(posedge clk) begin
    if (reset_) begin
      owner_q <= 2'd0;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Next owner: hold while the owner requests, otherwise first requester after it.
  always_comb begin
    owner_d    = owner_q;
    scan_idx   = 2'd0;
    scan_found = 1'b0;
    if (!req[owner_q]) begin
      for (int k = 1; k < 4; k++) begin
        scan_idx = owner_q + 2'(k);
        if (req[scan_idx] && !scan_found) begin
          owner_d    = scan_idx;
          scan_found = 1'b1;
        end
      end
    end
  end

  // One-cold grants decoded from the owner.
  for (genvar gi = 0; gi < 4; gi++) begin : g_grant
    assign grant_n[gi] = (owner_q != 2'(gi));
  end

  // Output drive: grants, owner-to-slave-bus mux, chip-select decode, read return.
  always_comb begin
    bus.m0Grnt_ = grant_n[0];
    bus.m1Grnt_ = grant_n[1];
    bus.m2Grnt_ = grant_n[2];
    bus.m3Grnt_ = grant_n[3];

    bus.sAddr = m_addr[owner_q];
    bus.sAs_  = m_as_n[owner_q];
    bus.sRW   = m_rw[owner_q];
    bus.sData = m_data[owner_q];

    // Decode does not look at sAs_; slaves qualify CS_ with the strobe.
    sel  = m_addr[owner_q][ADDR_W-1 -: SEL_W];
    cs_n = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (sel == SEL_W'(k)) cs_n[k] = 1'b0;
    end
    bus.s0CS_ = cs_n[0];
    bus.s1CS_ = cs_n[1];
    bus.s2CS_ = cs_n[2];
    bus.s3CS_ = cs_n[3];
    bus.s4CS_ = cs_n[4];
    bus.s5CS_ = cs_n[5];
    bus.s6CS_ = cs_n[6];
    bus.s7CS_ = cs_n[7];

    // Only the selected slave reaches the masters; idle bus value if none selected.
    bus.mRdData = '0;
    bus.mRdy_   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (!cs_n[k]) begin
        bus.mRdData = s_rd[k];
        bus.mRdy_   = s_rdy_n[k];
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed and randomized checks of bus_fabric against a round-robin reference model.
module tb_bus_fabric;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset_ = 1'b1;
  always #5 clk = ~clk;

  bus_fabric_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_fabric #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(3)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bif)
  );

  // stimulus state
  logic [3:0]        req_n;
  logic [ADDR_W-1:0] addr [4];
  logic [3:0]        as_n;
  logic [3:0]        rw;
  logic [DATA_W-1:0] wdata [4];
  logic [DATA_W-1:0] srd [8];
  logic [7:0]        srdy_n;

  // reference model state
  int unsigned model_owner;
  int tests = 0;
  int fails = 0;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    bif.m0Req_ = req_n[0]; bif.m1Req_ = req_n[1]; bif.m2Req_ = req_n[2]; bif.m3Req_ = req_n[3];
    bif.m0Addr = addr[0];  bif.m1Addr = addr[1];  bif.m2Addr = addr[2];  bif.m3Addr = addr[3];
    bif.m0As_  = as_n[0];  bif.m1As_  = as_n[1];  bif.m2As_  = as_n[2];  bif.m3As_  = as_n[3];
    bif.m0RW   = rw[0];    bif.m1RW   = rw[1];    bif.m2RW   = rw[2];    bif.m3RW   = rw[3];
    bif.m0Data = wdata[0]; bif.m1Data = wdata[1]; bif.m2Data = wdata[2]; bif.m3Data = wdata[3];
    bif.s0RdData = srd[0]; bif.s1RdData = srd[1]; bif.s2RdData = srd[2]; bif.s3RdData = srd[3];
    bif.s4RdData = srd[4]; bif.s5RdData = srd[5]; bif.s6RdData = srd[6]; bif.s7RdData = srd[7];
    bif.s0Rdy_ = srdy_n[0]; bif.s1Rdy_ = srdy_n[1]; bif.s2Rdy_ = srdy_n[2]; bif.s3Rdy_ = srdy_n[3];
    bif.s4Rdy_ = srdy_n[4]; bif.s5Rdy_ = srdy_n[5]; bif.s6Rdy_ = srdy_n[6]; bif.s7Rdy_ = srdy_n[7];
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) begin
      addr[i]  = ADDR_W'($urandom);
      wdata[i] = $urandom;
      as_n[i]  = 1'($urandom);
      rw[i]    = 1'($urandom);
    end
    for (int k = 0; k < 8; k++) srd[k] = $urandom;
    srdy_n = 8'($urandom);
  endtask

  // Arbitration rule: keep a requesting owner; otherwise the requester at the
  // smallest positive round-robin distance from the owner; otherwise park.
  task automatic model_edge();
    int best_d;
    int best_i;
    if (reset_) begin
      model_owner = 0;
    end else if (req_n[model_owner] == 1'b1) begin
      best_d = 4;
      best_i = int'(model_owner);
      for (int i = 0; i < 4; i++) begin
        int d;
        d = (i - int'(model_owner) + 4) % 4;
        if (req_n[i] == 1'b0 && d > 0 && d < best_d) begin
          best_d = d;
          best_i = i;
        end
      end
      model_owner = best_i;
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned sel;
    logic [3:0] exp_grant;
    logic [7:0] exp_cs;
    exp_grant = 4'hF;
    exp_grant[model_owner] = 1'b0;
    sel = addr[model_owner] >> (ADDR_W - 3);
    exp_cs = 8'hFF;
    exp_cs[sel] = 1'b0;
    cmp({tag, ".grant"}, 64'({bif.m3Grnt_, bif.m2Grnt_, bif.m1Grnt_, bif.m0Grnt_}), 64'(exp_grant));
    cmp({tag, ".sAddr"}, 64'(bif.sAddr), 64'(addr[model_owner]));
    cmp({tag, ".sAs_"},  64'(bif.sAs_),  64'(as_n[model_owner]));
    cmp({tag, ".sRW"},   64'(bif.sRW),   64'(rw[model_owner]));
    cmp({tag, ".sData"}, 64'(bif.sData), 64'(wdata[model_owner]));
    cmp({tag, ".cs"}, 64'({bif.s7CS_, bif.s6CS_, bif.s5CS_, bif.s4CS_,
                           bif.s3CS_, bif.s2CS_, bif.s1CS_, bif.s0CS_}), 64'(exp_cs));
    cmp({tag, ".mRdData"}, 64'(bif.mRdData), 64'(srd[sel]));
    cmp({tag, ".mRdy_"},   64'(bif.mRdy_),   64'(srdy_n[sel]));
    $display("[TB] %s owner=%0d sel=%0d sAddr=%h mRdData=%h", tag, model_owner, sel, bif.sAddr, bif.mRdData);
  endtask

  // One clock: apply stimulus at the falling edge, model the rising edge, check after it.
  task automatic cycle(input string tag);
    @(negedge clk);
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_owner = 0;
    req_n = 4'hF;
    randomize_data();
    drive();

    // reset, no requests; m0 address decodes to slave 1
    reset_ = 1'b1;
    addr[0] = 30'h0800_0000;
    cycle("reset");
    reset_ = 1'b0;
    cycle("park0");

    // m2 and m3 request together while owner 0 is idle -> nearest (2) wins
    req_n = 4'b0011;
    randomize_data();
    cycle("rr_to2");
    cmp("owner_is2", 64'(bif.m2Grnt_), 64'(0));

    // owner 2 releases, m3 requests -> 3; then only m1 -> wraps to 1
    req_n = 4'b0111;
    cycle("to3");
    req_n = 4'b1101;
    randomize_data();
    cycle("wrap_to1");

    // owner 1 holds for 10 cycles while others request
    for (int c = 0; c < 10; c++) begin
      req_n = {3'($urandom), 1'b0};
      req_n[1] = 1'b0;
      randomize_data();
      cycle("hold1");
    end

    // sweep slave select with owner 1 still holding, including address extremes
    for (int k = 0; k < 8; k++) begin
      randomize_data();
      req_n = 4'b1101;
      addr[1] = {3'(k), 27'($urandom)};
      for (int j = 0; j < 8; j++) srd[j] = 32'hA000_0000 + 32'(j);
      srdy_n = 8'hFF ^ (8'h01 << ((k * 3) % 8));
      cycle("sel_sweep");
    end
    addr[1] = 30'h3FFF_FFFF;
    cycle("addr_max");
    addr[1] = 30'h0000_0000;
    cycle("addr_min");

    // move ownership to 2, then reset while 2 keeps requesting
    req_n = 4'b1011;
    cycle("to2_again");
    cmp("owner2_before_reset", 64'(bif.m2Grnt_), 64'(0));
    reset_ = 1'b1;
    cycle("reset_mid");
    reset_ = 1'b0;
    cycle("post_reset");

    // randomized traffic with occasional resets
    for (int c = 0; c < 300; c++) begin
      randomize_data();
      req_n  = 4'($urandom) | 4'($urandom);
      reset_ = ($urandom_range(0, 39) == 0);
      cycle("random");
    end
    reset_ = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
